// File: rtl/softmax_max_sub.sv
// Subtracts the row (LSA) or 8-vector group (GSA) maximum from every lane; first beat one cycle after the last accept.
// in_ready drops for the whole emit phase; out_data/max_out hold while out_ready is low.
module softmax_max_sub #(
    parameter int bw          = 8,
    parameter int softmax_col = 8,
    parameter int group       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [bw*softmax_col-1:0] in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [bw*softmax_col-1:0] out_data,
    input  logic                      out_ready,
    output logic [bw-1:0]             max_out,
    output logic                      busy
);
    localparam int DW = bw * softmax_col;
    localparam int CW = $clog2(group);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t               state;
    logic [DW-1:0]        vec_buf [group];
    logic signed [bw-1:0] gmax;
    logic signed [bw-1:0] in_max;
    logic signed [bw-1:0] grp_max;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        idx;
    logic [CW-1:0]        last_idx;
    logic                 cur_mode;
    logic                 accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        in_max = $signed(in_data[bw-1:0]);
        for (int i = 1; i < softmax_col; i++) begin
            if ($signed(in_data[bw*i +: bw]) > in_max) begin
                in_max = $signed(in_data[bw*i +: bw]);
            end
        end
        grp_max = (in_max > gmax) ? in_max : gmax;
    end

    // (bw+1)-bit difference always lands in 0..2^bw-1, so the low bits are exact.
    always_comb begin
        logic [bw:0] diff;
        diff     = '0;
        out_data = '0;
        for (int i = 0; i < softmax_col; i++) begin
            diff = {gmax[bw-1], gmax} - {vec_buf[idx][bw*i+bw-1], vec_buf[idx][bw*i +: bw]};
            out_data[bw*i +: bw] = diff[bw-1:0];
        end
    end

    assign max_out  = gmax;
    assign busy     = (state != IDLE);
    assign last_idx = cur_mode ? CW'(group - 1) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gmax      <= '0;
            cnt       <= '0;
            idx       <= '0;
            cur_mode  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            for (int k = 0; k < group; k++) begin
                vec_buf[k] <= '0;
            end
        end else if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        vec_buf[0] <= in_data;
                        gmax       <= in_max;
                        cur_mode   <= (mode == 2'd1);
                        idx        <= '0;
                        if (mode == 2'd1) begin
                            state <= COLLECT;
                            cnt   <= CW'(1);
                        end else begin
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        vec_buf[cnt] <= in_data;
                        gmax         <= grp_max;
                        cnt          <= cnt + CW'(1);
                        if (cnt == CW'(group - 1)) begin
                            state     <= EMIT;
                            cnt       <= '0;
                            idx       <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (idx == last_idx) begin
                            state     <= IDLE;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/softmax_max_sub.md
# softmax_max_sub

Upstream pre-processing stage for the softmax unit. It accepts 8-lane signed 8-bit score vectors from the Q memory read path and subtracts a row maximum from every lane:
- LSA mode: the maximum of each vector.
- GSA mode: the maximum over an 8-vector group.

It emits unsigned non-negative distances d = max − x. The downstream exp-LUT stage indexes these by MSB/LSB nibble to form exp(−d).

## Interface
- bw, 8, element bit width
- softmax_col, 8, lanes per vector
- group, 8, vectors per GSA group
---
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mode  in  2  0 = LSA (per vector), 1 = GSA (per group); 2/3 treated as LSA
- clear  in  1  synchronous abort; returns to IDLE and drops buffered data
- in_valid  in  1  input vector valid
- in_data  in  bw*softmax_col  lane i at [bw*i +: bw], two's complement
- in_ready  out  1  registered; stage accepts when in_valid & in_ready
- out_valid  out  1  registered output vector valid
- out_data  out  bw*softmax_col  lane i = max − x_i, unsigned
- out_ready  in  1  downstream accept
- max_out  out  bw  signed maximum used for the current out_data
- busy  out  1  state != IDLE

## Operation
- Storage:
  - buf[0..group−1], each bw*softmax_col.
  - cnt: 3-bit collect index. idx: 3-bit emit index.
  - cur_mode: mode latched on the first accept of a group.
  - gmax: signed bw.
- rowmax(v): signed maximum of the 8 lanes, combinational tree.
- Subtraction: per lane, (bw+1)-bit signed max − x. The result always lies in 0..255 and is emitted as its low bw bits. No saturation is ever needed; for example 127 − (−128) = 0xFF.
- States: IDLE, COLLECT, EMIT.
- IDLE, on accept:
  - buf[0] ← in_data; gmax ← rowmax(in_data); cur_mode ← mode.
  - LSA: go to EMIT with idx = 0 and emit count 1.
  - GSA: go to COLLECT with cnt = 1.
- COLLECT, on accept:
  - buf[cnt] ← in_data; gmax ← max(gmax, rowmax(in_data)); cnt++.
  - On the accept with cnt = group−1, go to EMIT with idx = 0 and emit count = group.
- EMIT:
  - in_ready = 0.
  - out_data = gmax − buf[idx] per lane; max_out = gmax; out_valid = 1.
  - On out_valid & out_ready: idx++. After the last handshake, go to IDLE with out_valid = 0 and in_ready = 1 on the next cycle.
- mode changes after the first accept of a group are ignored until the group completes.
- clear: on the next edge, state ← IDLE, cnt = idx = 0, out_valid = 0, in_ready = 1. Contents of buf and gmax are don't-care. clear has priority over any simultaneous handshake.
- Reset (asserted low):
  - State IDLE. in_ready = 0, out_valid = 0, busy = 0, out_data = 0, max_out = 0, all counters 0.
  - in_ready rises on the first edge after release.
  - Reset mid-group discards the partial group with no residual effect.

## Timing
- LSA latency: a vector accepted at edge N has out_valid high after edge N+1, i.e. it is visible one cycle after acceptance.
- LSA throughput: 1 vector per 2 cycles with out_ready held high.
- GSA: the 8th accept at edge N gives out_valid high after edge N+1. Eight output beats follow on consecutive cycles when out_ready stays high.
- in_ready falls on the same edge that accepts the last vector of a group (LSA: every accept). It returns high on the edge of the final output handshake.
- While out_valid = 1 and out_ready = 0, out_data, max_out and idx hold stable.
- No input is ever accepted in EMIT, so there are no simultaneous accept/emit hazards.

## Test plan
- Reset, then LSA: in_data = 0x20_10_FF_00_80_7F_02_01 (lane 7 … lane 0) → one beat, out_data = 0x5F_6F_80_7F_FF_00_7D_7E, max_out = 0x7F, out_valid high exactly one cycle after accept.
- GSA: vector k has all lanes = k (k = 0..7), except vector 5 lane 3 = 0x40 → 8 beats:
  - beat 0: all lanes 0x40.
  - beat 5: lane 3 = 0x00, other lanes 0x3B.
  - beat 7: all lanes 0x39.
  - max_out = 0x40 on every beat; in_ready = 0 throughout.
- All lanes 0x80 (LSA) → out_data = 0, max_out = 0x80. Then a vector with all lanes 0x7F → out_data = 0, max_out = 0x7F.
- Backpressure in GSA: out_ready low for 3 cycles at beat 2 → beat-2 data held, no skipped or duplicated beat, 8 beats total.
- Reset asserted after 4 GSA accepts, then a fresh 8-vector group → outputs depend only on the new group.
- clear asserted during EMIT beat 3 with out_ready = 1 → next cycle IDLE, out_valid = 0, in_ready = 1. A following LSA vector processes normally.
